// File: rtl/alarm_buzzer_ctrl.sv
// Alarm buzzer controller: qualifies the alarm decision against glitches, then
// drives a bounded on/off beep pattern that the driver can silence until re-arm.
module alarm_buzzer_ctrl #(
  parameter int DEBOUNCE  = 4,
  parameter int ON_CYC    = 3,
  parameter int OFF_CYC   = 3,
  parameter int MAX_BEEPS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sAlr,
  input  logic                           sAck,
  output logic                           sBuzz,
  output logic                           sActive,
  output logic                           sMuted,
  output logic [$clog2(MAX_BEEPS+1)-1:0] sBeepCnt
);

  localparam int BEEP_W  = $clog2(MAX_BEEPS + 1);
  localparam int CNT_MAX = (DEBOUNCE > ON_CYC)
                         ? ((DEBOUNCE > OFF_CYC) ? DEBOUNCE : OFF_CYC)
                         : ((ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC);
  // The shared phase counter only ever reaches CNT_MAX-1.
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYC - 1);
  localparam logic [BEEP_W-1:0] BEEP_MAX = BEEP_W'(MAX_BEEPS);
  localparam logic [BEEP_W-1:0] BEEP_ONE = BEEP_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    QUALIFY,
    BEEP_ON,
    BEEP_OFF,
    HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BEEP_W-1:0]  beep_q, beep_d;
  logic               buzz_q, active_q, muted_q;

  // Next-state and counter logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    beep_d  = beep_q;

    case (state_q)
      IDLE: begin
        beep_d = '0;
        cnt_d  = CNT_ZERO;
        if (sAlr) begin
          if (DEBOUNCE == 1) begin
            state_d = BEEP_ON;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = QUALIFY;
            cnt_d   = CNT_ONE;
          end
        end
      end

      QUALIFY: begin
        if (!sAlr) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
          beep_d  = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = BEEP_ON;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      BEEP_ON: begin
        if (!sAlr) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
          beep_d  = '0;
        end else if (sAck) begin
          state_d = HOLD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == ON_LAST) begin
          state_d = BEEP_OFF;
          cnt_d   = CNT_ZERO;
          if (beep_q != BEEP_MAX) beep_d = beep_q + BEEP_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      BEEP_OFF: begin
        if (!sAlr) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
          beep_d  = '0;
        end else if (sAck) begin
          state_d = HOLD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == OFF_LAST) begin
          state_d = (beep_q == BEEP_MAX) ? HOLD : BEEP_ON;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      HOLD: begin
        // A held alarm never retriggers; only a clear re-arms the block.
        if (!sAlr) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
          beep_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
        beep_d  = '0;
      end
    endcase
  end

  // State register plus outputs decoded from the next state, so each output
  // changes on the same edge as the state it reflects.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      beep_q   <= '0;
      buzz_q   <= 1'b0;
      active_q <= 1'b0;
      muted_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beep_q   <= beep_d;
      buzz_q   <= (state_d == BEEP_ON);
      active_q <= (state_d == BEEP_ON) || (state_d == BEEP_OFF);
      muted_q  <= (state_d == HOLD);
    end
  end

  assign sBuzz    = buzz_q;
  assign sActive  = active_q;
  assign sMuted   = muted_q;
  assign sBeepCnt = beep_q;

endmodule

// File: tb/tb_alarm_buzzer_ctrl.sv
// Self-checking bench for alarm_buzzer_ctrl: directed scenarios plus random
// stimulus, compared every cycle against an episode-timer reference model.
module tb_alarm_buzzer_ctrl;

  localparam int DEB  = 4;
  localparam int ON   = 3;
  localparam int OFF  = 3;
  localparam int MAXB = 2;
  localparam int P    = ON + OFF;
  localparam int BW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          sAlr;
  logic          sAck;
  logic          sBuzz;
  logic          sActive;
  logic          sMuted;
  logic [BW-1:0] sBeepCnt;

  int checks = 0;
  int errors = 0;

  // Reference model: consecutive-alarm run length, then elapsed time t since
  // beeping began; buzzer level and beep count follow from t by arithmetic.
  bit m_beeping;
  bit m_muted;
  int m_run;
  int m_t;
  int m_hold_cnt;

  alarm_buzzer_ctrl #(
    .DEBOUNCE (DEB),
    .ON_CYC   (ON),
    .OFF_CYC  (OFF),
    .MAX_BEEPS(MAXB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sAlr    (sAlr),
    .sAck    (sAck),
    .sBuzz   (sBuzz),
    .sActive (sActive),
    .sMuted  (sMuted),
    .sBeepCnt(sBeepCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int beeps_done(input int t);
    return t / P + (((t % P) >= ON) ? 1 : 0);
  endfunction

  task automatic model_clear();
    m_beeping  = 1'b0;
    m_muted    = 1'b0;
    m_run      = 0;
    m_t        = 0;
    m_hold_cnt = 0;
  endtask

  task automatic model_step(input logic a, input logic k, input logic r);
    if (r || !a) begin
      model_clear();
    end else if (m_muted) begin
      // silenced until the alarm clears
    end else if (m_beeping) begin
      if (k) begin
        m_muted    = 1'b1;
        m_hold_cnt = beeps_done(m_t);
      end else begin
        m_t++;
        if (m_t == MAXB * P) begin
          m_muted    = 1'b1;
          m_hold_cnt = MAXB;
        end
      end
    end else begin
      m_run++;
      if (m_run == DEB) begin
        m_beeping = 1'b1;
        m_t       = 0;
      end
    end
  endtask

  task automatic compare_all();
    bit act;
    int cnt;
    act = m_beeping && !m_muted;
    cnt = m_muted ? m_hold_cnt : (m_beeping ? beeps_done(m_t) : 0);
    check("buzz",   sBuzz,    act && ((m_t % P) < ON));
    check("active", sActive,  act);
    check("muted",  sMuted,   m_muted);
    check("count",  sBeepCnt, cnt);
  endtask

  task automatic step(input logic a, input logic k, input logic r);
    sAlr  = a;
    sAck  = k;
    reset = r;
    @(posedge clk);
    #1;
    model_step(a, k, r);
    compare_all();
  endtask

  initial begin
    int first_rise;
    int high_cycles;
    model_clear();
    sAlr  = 1'b0;
    sAck  = 1'b0;
    reset = 1'b1;

    // Power-on reset.
    step(0, 0, 1);
    step(0, 0, 1);
    check("por_buzz", sBuzz, 0);
    check("por_cnt", sBeepCnt, 0);

    // Reset applied mid-beep with the alarm still asserted.
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    check("midbeep_buzz", sBuzz, 1);
    step(1, 0, 1);
    check("rst_buzz", sBuzz, 0);
    check("rst_active", sActive, 0);
    check("rst_muted", sMuted, 0);
    check("rst_cnt", sBeepCnt, 0);
    step(1, 0, 1);
    step(0, 0, 0);

    // Glitch shorter than the debounce window.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      check("glitch_buzz", sBuzz, 0);
    end
    step(0, 0, 0);
    check("glitch_idle_active", sActive, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // Full episode with the alarm held.
    first_rise  = -1;
    high_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      if (sBuzz === 1'b1) begin
        high_cycles++;
        if (first_rise < 0) first_rise = i;
      end
      if (i == 14) check("ep_muted_e14", sMuted, 0);
      if (i == 15) begin
        check("ep_muted_e15", sMuted, 1);
        check("ep_cnt_e15", sBeepCnt, MAXB);
      end
    end
    check("ep_first_rise", first_rise, DEB - 1);
    check("ep_high_cycles", high_cycles, MAXB * ON);
    check("ep_still_muted", sMuted, 1);
    step(0, 0, 0);
    check("ep_unmute", sMuted, 0);
    check("ep_cnt_clear", sBeepCnt, 0);

    // Acknowledge on the 2nd cycle of the first beep.
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    step(1, 1, 0);
    check("ack_buzz", sBuzz, 0);
    check("ack_muted", sMuted, 1);
    check("ack_cnt", sBeepCnt, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    check("ack_no_rebeep", sBuzz, 0);
    step(0, 0, 0);

    // Alarm clear and acknowledge on the same edge during BEEP_OFF.
    for (int i = 0; i < 7; i++) step(1, 0, 0);
    check("simul_in_off", sActive && !sBuzz, 1);
    step(0, 1, 0);
    check("simul_muted", sMuted, 0);
    check("simul_active", sActive, 0);

    // Re-arm after HOLD.
    for (int i = 0; i < 16; i++) step(1, 0, 0);
    check("rearm_hold", sMuted, 1);
    step(0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0);
      if (i == 2) check("rearm_not_yet", sBuzz, 0);
      if (i == 3) begin
        check("rearm_rise", sBuzz, 1);
        check("rearm_cnt0", sBeepCnt, 0);
      end
      if (i == 6) check("rearm_cnt1", sBeepCnt, 1);
    end
    step(0, 0, 0);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) < 88) ? 1'b1 : 1'b0,
           ($urandom_range(99) < 4)  ? 1'b1 : 1'b0,
           ($urandom_range(99) < 1)  ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_buzzer_ctrl.md
# alarm_buzzer_ctrl

Downstream consumer of the combinational alarm decision `sAlr` (lights on, door open, ignition off). It qualifies `sAlr` against glitches, then drives a buzzer with a bounded on/off beep pattern. The driver can silence it with an acknowledge, and it re-arms only after the alarm condition clears. All outputs are registered on one clock.

## Interface
- `DEBOUNCE`, 4: consecutive cycles `sAlr` must be sampled 1 before beeping starts; legal range ≥1.
- `ON_CYC`, 3: cycles `sBuzz` is high per beep; legal range ≥1.
- `OFF_CYC`, 3: cycles `sBuzz` is low between beeps; legal range ≥1.
- `MAX_BEEPS`, 8: beeps emitted before automatic silencing; legal range ≥1.
- `clk`  input  1  clock. All logic runs on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `sAlr`  input  1  alarm condition from the alarm decision logic. Synchronous to `clk`.
- `sAck`  input  1  driver acknowledge/silence request. Level-sampled.
- `sBuzz`  output  1  buzzer drive.
- `sActive`  output  1  high while in BEEP_ON or BEEP_OFF.
- `sMuted`  output  1  high while in HOLD.
- `sBeepCnt`  output  $clog2(MAX_BEEPS+1)  number of completed beeps in the current episode.

## Operation
- States: IDLE, QUALIFY, BEEP_ON, BEEP_OFF, HOLD. A single phase counter `cnt` is shared by QUALIFY, BEEP_ON and BEEP_OFF.
- Reset (`reset`=1 at an edge), taking priority over everything:
  - state ← IDLE, `cnt` ← 0, `sBeepCnt` ← 0.
  - `sBuzz`, `sActive`, `sMuted` ← 0.
  - Applies mid-beep as well; no partial-beep completion.
- IDLE:
  - `sAlr`=1 and `DEBOUNCE`=1 → BEEP_ON, `cnt`←0.
  - `sAlr`=1 and `DEBOUNCE`>1 → QUALIFY, `cnt`←1.
  - Otherwise stay.
  - `sBeepCnt` ← 0 on entry.
- QUALIFY:
  - `sAlr`=0 → IDLE (glitch rejected).
  - Else if `cnt`=`DEBOUNCE`-1 → BEEP_ON, `cnt`←0.
  - Else `cnt`++.
- BEEP_ON and BEEP_OFF: priority is `sAlr`=0, then `sAck`=1, then timing.
  - `sAlr`=0 → IDLE.
  - `sAck`=1 → HOLD.
  - BEEP_ON timing: if `cnt`=`ON_CYC`-1 → BEEP_OFF, `cnt`←0, `sBeepCnt`++. Else `cnt`++.
  - BEEP_OFF timing: if `cnt`=`OFF_CYC`-1 → HOLD when `sBeepCnt`=`MAX_BEEPS`, else BEEP_ON with `cnt`←0. Otherwise `cnt`++.
- HOLD:
  - `sAlr`=0 → IDLE.
  - Otherwise stay; `sAck` is ignored.
  - A continuously asserted `sAlr` never retriggers beeping.
- `sAck` in IDLE or QUALIFY has no effect.
- Output decode, registered and aligned with the state register:
  - `sBuzz`=1 iff state is BEEP_ON.
  - `sActive`=1 iff state is BEEP_ON or BEEP_OFF.
  - `sMuted`=1 iff state is HOLD.
- `sBeepCnt` saturates at `MAX_BEEPS` and never wraps. It holds its value in HOLD and clears on entering IDLE.

## Timing
- Edge numbering: E0 is the first edge sampling `sAlr`=1 from IDLE.
- With `sAlr` held at 1, `sBuzz` rises after edge E(`DEBOUNCE`-1). That is `DEBOUNCE` edges of latency, with the first sample counted.
- Each beep: `sBuzz` high exactly `ON_CYC` cycles, then low exactly `OFF_CYC` cycles.
- `sBeepCnt` increments on the edge where `sBuzz` falls.
- Full episode: `sMuted` rises `DEBOUNCE` + `MAX_BEEPS`·(`ON_CYC`+`OFF_CYC`) edges after E0, counting E0.
- `sAck` sampled 1 at edge k in a beep state: `sBuzz`=0 and `sMuted`=1 from edge k onward. One-edge response, no delay.
- `sAlr` sampled 0 at edge k in any non-IDLE state: state IDLE and all outputs 0 after edge k.
- `sAlr` and `sAck` both asserted on the same edge in a beep state: `sAlr`=0 wins, so the result is IDLE, not HOLD.
- Re-arm: after HOLD→IDLE, a fresh `DEBOUNCE` qualification is required.

## Test plan
All scenarios use `DEBOUNCE`=4, `ON_CYC`=3, `OFF_CYC`=3, `MAX_BEEPS`=2.
- Reset check: hold `reset` high for 2 cycles, with `sAlr`=1 in the middle of a beep → all outputs 0 and `sBeepCnt`=0 on the edge after reset is sampled.
- Glitch rejection: `sAlr`=1 for 3 cycles, then 0 → `sBuzz` never rises and the block returns to IDLE.
- Full episode: `sAlr` held 1 → `sBuzz` pattern 3 high / 3 low / 3 high / 3 low, with the first rise after E3. Then `sMuted`=1 after E15 with `sBeepCnt`=2. `sMuted` stays 1 while `sAlr`=1 and clears on the edge where `sAlr`=0 is sampled.
- Acknowledge: `sAck` pulsed for 1 cycle on the 2nd cycle of beep 1 → `sBuzz`=0 and `sMuted`=1 on that edge, `sBeepCnt`=0. `sAlr` stays 1, so no further beeps.
- Simultaneous events: `sAck`=1 and `sAlr`=0 on the same edge during BEEP_OFF → IDLE, `sMuted`=0.
- Re-arm: after HOLD, drop `sAlr` for 1 cycle, then reassert → beeping restarts after 4 qualifying edges with `sBeepCnt` counting from 0.
